// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: shares one single-port memory backend between the fetch
// and data ports. Optional watchdog: define CONFIG_MEM_ARB_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e      state_q;
  logic        owner_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        if_ready_q, if_rvalid_q, if_err_q;
  logic [31:0] if_rdata_q;
  logic        d_ready_q, d_rvalid_q, d_err_q;
  logic [31:0] d_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        busy_q;

  logic        fetch_win, data_win;
  logic        tmo, fin_ok, fin_tmo;
  logic [31:0] fin_data;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      if (if_req && (!d_req || starve_q == STARVE_CAP)) begin
        fetch_win = 1'b1;
        starve_d  = '0;
      end else if (d_req) begin
        data_win = 1'b1;
        if (!if_req) begin
          starve_d = '0;
        end else if (starve_q != STARVE_CAP) begin
          starve_d = starve_q + 4'd1;
        end
      end
    end
  end

`ifdef CONFIG_MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdog_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else if (state_q == IDLE || tmo || (state_q == ISSUE && mem_ack)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  assign tmo = (state_q != IDLE) && (wdog_q == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  // A real completion or an ack takes precedence over a coincident timeout.
  assign fin_ok   = (state_q == WAIT) && mem_rvalid;
  assign fin_tmo  = tmo && !fin_ok && !((state_q == ISSUE) && mem_ack);
  assign fin_data = (fin_tmo || mem_we_q) ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      starve_q    <= '0;
      if_ready_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_ready_q   <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      starve_q    <= starve_d;

      case (state_q)
        IDLE: begin
          if (fetch_win || data_win) begin
            state_q   <= ISSUE;
            busy_q    <= 1'b1;
            mem_req_q <= 1'b1;
            owner_q   <= data_win;
            if (data_win) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_be_q    <= d_be;
              d_ready_q   <= 1'b1;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= 4'hF;
              if_ready_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: ;
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase

      if (fin_ok || fin_tmo) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        mem_req_q <= 1'b0;
        if (owner_q) begin
          d_rvalid_q <= 1'b1;
          d_err_q    <= fin_tmo;
          d_rdata_q  <= fin_data;
        end else begin
          if_rvalid_q <= 1'b1;
          if_err_q    <= fin_tmo;
          if_rdata_q  <= fin_data;
        end
      end
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_ready   = d_ready_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
